intlv_frame_ctrl: RTL and testbench

- Frame-level sequencer for the SAT-uplink interleaver enable/address generator.
- Accepts one frame command (link_id 20..24) at a time and maps it to the frame length m_len.
- Drives the write phase: start pulse, then a contiguous burst from the upstream source.
- Then drives the read phase: paced `request` strobes under downstream backpressure, and reports frame completion.

---
 rtl/intlv_pkg.sv | 30 +++
 rtl/intlv_len_lut.sv | 25 ++
 rtl/intlv_frame_ctrl.sv | 105 ++++++++++
 tb/tb_intlv_frame_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/intlv_pkg.sv
// Shared constants for the interleaver frame controller:
// link-id to frame-length map, state encoding, default turnaround gap.
package intlv_pkg;

    localparam int PKG_LEN_W   = 13;
    localparam int GAP_CYC_DEF = 2;

    localparam logic [4:0] LINK_ID_20 = 5'd20;
    localparam logic [4:0] LINK_ID_21 = 5'd21;
    localparam logic [4:0] LINK_ID_22 = 5'd22;
    localparam logic [4:0] LINK_ID_23 = 5'd23;
    localparam logic [4:0] LINK_ID_24 = 5'd24;

    localparam logic [PKG_LEN_W-1:0] M_LEN_20 = 13'h060;
    localparam logic [PKG_LEN_W-1:0] M_LEN_21 = 13'h2E0;
    localparam logic [PKG_LEN_W-1:0] M_LEN_22 = 13'hC30;
    localparam logic [PKG_LEN_W-1:0] M_LEN_23 = 13'h11C0;
    localparam logic [PKG_LEN_W-1:0] M_LEN_24 = 13'hECC;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WAIT_SRC = 3'd2,
        ST_WRITE    = 3'd3,
        ST_GAP      = 3'd4,
        ST_READ     = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/intlv_len_lut.sv
// Link id to frame length lookup; flags ids outside the supported set.
module intlv_len_lut
    import intlv_pkg::*;
#(
    parameter int LEN_W = PKG_LEN_W
) (
    input  logic [4:0]       link_id,
    output logic [LEN_W-1:0] len,
    output logic             legal
);

    always_comb begin
        len   = '0;
        legal = 1'b1;
        unique case (1'b1)
            (link_id == LINK_ID_20): len = LEN_W'(M_LEN_20);
            (link_id == LINK_ID_21): len = LEN_W'(M_LEN_21);
            (link_id == LINK_ID_22): len = LEN_W'(M_LEN_22);
            (link_id == LINK_ID_23): len = LEN_W'(M_LEN_23);
            (link_id == LINK_ID_24): len = LEN_W'(M_LEN_24);
            default:                 legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/intlv_frame_ctrl.sv
// Frame sequencer: command accept, contiguous write burst,
// turnaround gap, then backpressured read strobes and completion pulse.
module intlv_frame_ctrl
    import intlv_pkg::*;
#(
    parameter int LEN_W   = 13,
    parameter int CNT_W   = 16,
    parameter int GAP_CYC = GAP_CYC_DEF
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             cmd_vld,
    input  logic [4:0]       cmd_link_id,
    output logic             cmd_rdy,
    input  logic             src_vld,
    output logic             src_rdy,
    input  logic             dst_rdy,
    output logic [LEN_W-1:0] m_len,
    output logic             din_vld,
    output logic             request,
    output logic             busy,
    output logic             frame_done,
    output logic             err_link
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       gap_cnt;
    logic [LEN_W-1:0] lut_len;
    logic             lut_legal;
    logic             last;

    intlv_len_lut #(.LEN_W(LEN_W)) u_lut (
        .link_id (cmd_link_id),
        .len     (lut_len),
        .legal   (lut_legal)
    );

    assign last = (cnt + CNT_W'(1)) == CNT_W'(m_len);

    // Strobes are decodes of registered state, gated only by the handshakes
    assign cmd_rdy    = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign din_vld    = (state == ST_WAIT_SRC) && src_vld;
    assign src_rdy    = (state == ST_WRITE) || din_vld;
    assign request    = (state == ST_READ) && dst_rdy;
    assign frame_done = (state == ST_DONE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            gap_cnt  <= '0;
            m_len    <= '0;
            err_link <= 1'b0;
        end else begin
            err_link <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cmd_vld) begin
                        if (lut_legal) begin
                            m_len <= lut_len;
                            state <= ST_LOAD;
                        end else begin
                            err_link <= 1'b1;
                        end
                    end
                end
                ST_LOAD: state <= ST_WAIT_SRC;
                ST_WAIT_SRC: begin
                    if (src_vld) begin
                        cnt <= CNT_W'(1);
                        if (m_len == LEN_W'(1)) state <= ST_GAP;
                        else                    state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last) state <= ST_GAP;
                end
                ST_GAP: begin
                    cnt <= '0;
                    if (gap_cnt == 3'(GAP_CYC - 1)) begin
                        gap_cnt <= '0;
                        state   <= ST_READ;
                    end else begin
                        gap_cnt <= gap_cnt + 3'd1;
                    end
                end
                ST_READ: begin
                    if (dst_rdy) begin
                        cnt <= cnt + CNT_W'(1);
                        if (last) state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intlv_frame_ctrl.sv
// Randomized frame-level bench for intlv_frame_ctrl against a
// cycle-window reference model built from the length map.
module tb_intlv_frame_ctrl;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        cmd_vld = 1'b0;
    logic [4:0]  cmd_link_id = '0;
    logic        src_vld = 1'b0;
    logic        dst_rdy = 1'b0;
    logic        cmd_rdy, src_rdy, din_vld, request;
    logic        busy, frame_done, err_link;
    logic [12:0] m_len;

    int total = 0;
    int bad = 0;
    int prev_len = 0;

    always #5 clk = ~clk;

    intlv_frame_ctrl dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .cmd_vld     (cmd_vld),
        .cmd_link_id (cmd_link_id),
        .cmd_rdy     (cmd_rdy),
        .src_vld     (src_vld),
        .src_rdy     (src_rdy),
        .dst_rdy     (dst_rdy),
        .m_len       (m_len),
        .din_vld     (din_vld),
        .request     (request),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_link    (err_link)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_len(input int id);
        case (id)
            20: return 96;
            21: return 736;
            22: return 3120;
            23: return 4544;
            24: return 3788;
            default: return 0;
        endcase
    endfunction

    function automatic logic [6:0] outs();
        return {cmd_rdy, busy, din_vld, src_rdy, request, frame_done, err_link};
    endfunction

    task automatic idle_after_reset();
        int n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            cmd_vld = 1'b0;
            @(negedge clk);
            if (frame_done || busy || !cmd_rdy) n++;
        end
        check("post_rst_idle", n, 0);
    endtask

    // mode: 0 dst_rdy high, 1 toggling, 2 random
    task automatic run_frame(input int id, input int dly, input int mode,
                             input bit hold, input int nxt, input int abort_c);
        int L, left, last_req, rd_start, budget;
        int nmis, nml, nwr, nrq, nnd;
        bit done_seen, ebusy, ereq, edone;
        logic [6:0] e;
        L = ref_len(id);
        left = L;
        last_req = -10;
        rd_start = 2 + dly + L + GAP;
        budget = rd_start + 3 * L + 20;
        nmis = 0; nml = 0; nwr = 0; nrq = 0; nnd = 0;
        done_seen = 1'b0;
        for (int c = 0; c < budget && !done_seen; c++) begin
            @(posedge clk); #1;
            cmd_vld = (c == 0) || hold;
            cmd_link_id = (c == 0) ? 5'(id) : 5'(nxt);
            src_vld = (c >= 2 + dly);
            case (mode)
                0: dst_rdy = 1'b1;
                1: dst_rdy = (c % 2 == 0);
                default: dst_rdy = 1'($urandom_range(0, 1));
            endcase
            if (c == abort_c) begin
                n_rst = 1'b0;
                @(negedge clk);
                check("rst_vec", {outs(), m_len}, {7'b1000000, 13'd0});
                check("pre_rst_sigs", nmis, 0);
                n_rst = 1'b1;
                cmd_vld = 1'b0;
                prev_len = 0;
                idle_after_reset();
                return;
            end
            ereq = 1'b0;
            if (c >= rd_start && left > 0 && dst_rdy) begin
                ereq = 1'b1;
                left--;
                if (left == 0) last_req = c;
            end
            edone = (left == 0) && (c == last_req + 1);
            ebusy = (c >= 1) && !(left == 0 && c > last_req + 1);
            e = {!ebusy, ebusy, (c == 2 + dly),
                 (c >= 2 + dly && c <= 1 + dly + L), ereq, edone, 1'b0};
            @(negedge clk);
            if (outs() !== e) nmis++;
            if (m_len !== 13'((c == 0) ? prev_len : L)) nml++;
            nwr += int'(src_rdy);
            nrq += int'(request);
            if (request && !dst_rdy) nnd++;
            if (frame_done === 1'b1) done_seen = 1'b1;
        end
        check($sformatf("sigs_%0d", id), nmis, 0);
        check($sformatf("mlen_%0d", id), nml, 0);
        check($sformatf("wr_n_%0d", id), nwr, L);
        check($sformatf("rq_n_%0d", id), nrq, L);
        check($sformatf("rq_nodst_%0d", id), nnd, 0);
        check($sformatf("done_%0d", id), done_seen, 1);
        prev_len = L;
    endtask

    task automatic bad_cmd(input int id);
        @(posedge clk); #1;
        cmd_vld = 1'b1;
        cmd_link_id = 5'(id);
        src_vld = 1'b0;
        dst_rdy = 1'b0;
        @(negedge clk);
        check("bad_rdy", cmd_rdy, 1);
        @(posedge clk); #1;
        cmd_vld = 1'b0;
        @(negedge clk);
        check("err_pulse", err_link, 1);
        check("bad_busy", busy, 0);
        check("bad_rdy2", cmd_rdy, 1);
        check("bad_mlen", m_len, prev_len);
        @(posedge clk); #1;
        @(negedge clk);
        check("err_clr", err_link, 0);
        check("bad_busy2", busy, 0);
    endtask

    initial begin
        int id;
        repeat (2) @(negedge clk);
        check("rst_hold", {outs(), m_len}, {7'b1000000, 13'd0});
        n_rst = 1'b1;
        @(negedge clk);
        check("rst_idle", {outs(), m_len}, {7'b1000000, 13'd0});

        run_frame(20, 0, 0, 1'b0, 0, -1);
        run_frame(23, 0, 1, 1'b0, 0, -1);
        bad_cmd(25);
        run_frame(21, 0, 2, 1'b0, 0, -1);
        run_frame(22, 0, 0, 1'b1, 24, -1);
        run_frame(24, 0, 0, 1'b0, 0, -1);
        run_frame(22, 0, 0, 1'b0, 0, 2 + 3120 + GAP + 40);
        run_frame(20, 0, 0, 1'b0, 0, -1);
        run_frame(20, 10, 0, 1'b0, 0, -1);

        for (int k = 0; k < 4; k++) begin
            id = int'($urandom_range(20, 26));
            if (id > 24) bad_cmd(id);
            else run_frame(id, int'($urandom_range(0, 5)), 2, 1'b0, 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
